// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg
//   Shared definitions for the data cache controller: FSM state encoding,
//   byte-offset width and the small byte-lane helpers used by both the
//   controller and the storage array.
//   No ports (package).
package dcache_ctrl_pkg;

    localparam int BYTE_OFF_W = 2;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    // Byte-lane enable for a store: all four lanes for a word store,
    // otherwise the single lane selected by the byte offset.
    function automatic logic [3:0] lane_mask(input logic is_word, input logic [1:0] boff);
        if (is_word) begin
            return 4'hF;
        end
        return 4'b0001 << boff;
    endfunction

    // Little-endian byte select.
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] boff);
        case (boff)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/dcache_ctrl_array.sv
// dcache_ctrl_array
//   Storage for the direct-mapped cache: per-line valid/dirty/tag plus the
//   data RAM organised as NUM_LINES x WORDS_PER_LINE 32-bit words.
//   Ports:
//     clock, rst           clock and synchronous active-high reset (valid/dirty only)
//     rd_idx, rd_word      combinational read port: line metadata + one data word
//     line_valid/dirty/tag metadata of line rd_idx
//     line_word            data word rd_word of line rd_idx
//     wr_en/wr_idx/wr_word/wr_be/wr_data
//                          synchronous data write with byte-lane enables
//     set_dirty, clr_dirty dirty-bit updates for line wr_idx
//     fill_done, fill_tag  line wr_idx becomes valid, clean, tagged fill_tag
module dcache_ctrl_array
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES      = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 26,
    localparam int IDX_W         = $clog2(NUM_LINES),
    localparam int WOFF_W        = $clog2(WORDS_PER_LINE)
) (
    input  logic                clock,
    input  logic                rst,
    input  logic [IDX_W-1:0]    rd_idx,
    input  logic [WOFF_W-1:0]   rd_word,
    output logic                line_valid,
    output logic                line_dirty,
    output logic [TAG_W-1:0]    line_tag,
    output logic [DATA_W-1:0]   line_word,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [WOFF_W-1:0]   wr_word,
    input  logic [3:0]          wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                set_dirty,
    input  logic                clr_dirty,
    input  logic                fill_done,
    input  logic [TAG_W-1:0]    fill_tag
);

    localparam int DEPTH = NUM_LINES * WORDS_PER_LINE;

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_d [NUM_LINES];
    logic [DATA_W-1:0]    data_q [DEPTH];

    logic [IDX_W+WOFF_W-1:0] wr_addr;
    logic [IDX_W+WOFF_W-1:0] rd_addr;

    assign wr_addr = {wr_idx, wr_word};
    assign rd_addr = {rd_idx, rd_word};

    // Metadata read depends on the line index only, so the controller can
    // decide hit/miss before choosing which word to read.
    assign line_valid = valid_q[rd_idx];
    assign line_dirty = dirty_q[rd_idx];
    assign line_tag   = tag_q[rd_idx];
    assign line_word  = data_q[rd_addr];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        if (set_dirty) begin
            dirty_d[wr_idx] = 1'b1;
        end
        if (clr_dirty) begin
            dirty_d[wr_idx] = 1'b0;
        end
        if (fill_done) begin
            valid_d[wr_idx] = 1'b1;
            dirty_d[wr_idx] = 1'b0;
            tag_d[wr_idx]   = fill_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tags are meaningless while the line is invalid, so they need no reset.
    always_ff @(posedge clock) begin
        tag_q <= tag_d;
    end

    // Data RAM: not reset; byte-lane write enables.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl
//   Direct-mapped, write-back, write-allocate data cache for the memory
//   stage. Hits complete combinationally; a miss raises stall while a dirty
//   victim is written back and the line is refilled one word at a time.
//   Ports:
//     clock, rst            clock, synchronous active-high reset
//     address, write_data   CPU byte address and store data
//     memRead, memWrite     load / store request (both set = store)
//     word                  1 = 32-bit access, 0 = byte access
//     read_data             load result (zero-extended for byte loads)
//     stall                 access not complete, hold the pipeline
//     mem_addr/mem_wdata/mem_req/mem_we
//                           main-memory request, word aligned
//     mem_rdata, mem_ready  main-memory read data and completion
//
//   Memory handshake: a beat is transferred on every rising edge where
//   mem_req and mem_ready are both 1. While mem_req is 1 and mem_ready is 0,
//   mem_addr, mem_we and mem_wdata hold their values; mem_ready is ignored
//   while mem_req is 0. mem_req stays high across the words of a line.
//
//   The miss-detect cycle already issues the first beat of the writeback or
//   refill, so with mem_ready tied high a clean miss stalls for 5 cycles and
//   completes on the 6th, and a dirty miss completes on the 10th.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES      = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              word,
    output logic [31:0]       read_data,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam int WOFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W    = $clog2(NUM_LINES);
    localparam int WOFF_LSB = BYTE_OFF_W;
    localparam int IDX_LSB  = WOFF_LSB + WOFF_W;
    localparam int TAG_LSB  = IDX_LSB + IDX_W;
    localparam int TAG_W    = ADDR_W - TAG_LSB;
    localparam logic [WOFF_W-1:0] LAST_WORD = WOFF_W'(WORDS_PER_LINE - 1);

    // Registered state (the FSM state is observable as state_q).
    state_e            state_q, state_d;
    logic [WOFF_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;

    // Address decode.
    logic [1:0]        cpu_boff;
    logic [WOFF_W-1:0] cpu_woff;
    logic [IDX_W-1:0]  cpu_idx;
    logic [TAG_W-1:0]  cpu_tag;
    logic              access;
    logic              in_idle;

    // "Effective" view: in IDLE the live CPU address, otherwise the address
    // latched at the miss. This lets the miss cycle act as the first beat.
    logic [IDX_W-1:0]  eff_idx;
    logic [TAG_W-1:0]  eff_tag;
    logic [WOFF_W-1:0] eff_cnt;
    state_e            eff_state;
    logic              hit;
    logic              miss;

    // Array interface.
    logic              line_valid, line_dirty;
    logic [TAG_W-1:0]  line_tag;
    logic [31:0]       line_word;
    logic [WOFF_W-1:0] arr_rd_word;
    logic              arr_we;
    logic [WOFF_W-1:0] arr_wword;
    logic [3:0]        arr_be;
    logic [31:0]       arr_wdata;
    logic              set_dirty, clr_dirty, fill_done;

    always_comb begin
        cpu_boff = address[1:0];
        cpu_woff = address[IDX_LSB-1:WOFF_LSB];
        cpu_idx  = address[TAG_LSB-1:IDX_LSB];
        cpu_tag  = address[ADDR_W-1:TAG_LSB];
        access   = memRead | memWrite;
        in_idle  = (state_q == ST_IDLE);
        eff_idx  = in_idle ? cpu_idx : miss_idx_q;
        eff_tag  = in_idle ? cpu_tag : miss_tag_q;
        eff_cnt  = in_idle ? '0 : cnt_q;
    end

    // Hit/miss uses only the index-addressed metadata; the data word read
    // is then chosen: the requested word on a hit, the counter word otherwise
    // (victim word during writeback).
    always_comb begin
        hit         = line_valid && (line_tag == cpu_tag);
        miss        = in_idle && access && !hit;
        arr_rd_word = (in_idle && hit) ? cpu_woff : eff_cnt;
        eff_state   = state_q;
        if (miss) begin
            eff_state = (line_valid && line_dirty) ? ST_WRITEBACK : ST_REFILL;
        end
    end

    dcache_ctrl_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_array (
        .clock      (clock),
        .rst        (rst),
        .rd_idx     (eff_idx),
        .rd_word    (arr_rd_word),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .line_word  (line_word),
        .wr_en      (arr_we),
        .wr_idx     (eff_idx),
        .wr_word    (arr_wword),
        .wr_be      (arr_be),
        .wr_data    (arr_wdata),
        .set_dirty  (set_dirty),
        .clr_dirty  (clr_dirty),
        .fill_done  (fill_done),
        .fill_tag   (eff_tag)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        stall      = 1'b0;
        read_data  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        arr_we     = 1'b0;
        arr_wword  = eff_cnt;
        arr_be     = 4'h0;
        arr_wdata  = '0;
        set_dirty  = 1'b0;
        clr_dirty  = 1'b0;
        fill_done  = 1'b0;

        if (miss) begin
            miss_idx_d = cpu_idx;
            miss_tag_d = cpu_tag;
            cnt_d      = '0;
        end

        case (eff_state)
            ST_IDLE: begin
                // Reaching here with an access means it hit.
                if (access) begin
                    if (memWrite) begin
                        arr_we    = 1'b1;
                        arr_wword = cpu_woff;
                        arr_be    = lane_mask(word, cpu_boff);
                        arr_wdata = word ? write_data : {4{write_data[7:0]}};
                        set_dirty = 1'b1;
                    end else begin
                        read_data = word ? line_word : {24'd0, pick_byte(line_word, cpu_boff)};
                    end
                end
            end

            ST_WRITEBACK: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {line_tag, eff_idx, eff_cnt, 2'b00};
                mem_wdata = line_word;
                state_d   = ST_WRITEBACK;
                cnt_d     = eff_cnt;
                if (mem_ready) begin
                    if (eff_cnt == LAST_WORD) begin
                        clr_dirty = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_REFILL;
                    end else begin
                        cnt_d = eff_cnt + 1'b1;
                    end
                end
            end

            ST_REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {eff_tag, eff_idx, eff_cnt, 2'b00};
                state_d  = ST_REFILL;
                cnt_d    = eff_cnt;
                if (mem_ready) begin
                    arr_we    = 1'b1;
                    arr_be    = 4'hF;
                    arr_wdata = mem_rdata;
                    if (eff_cnt == LAST_WORD) begin
                        fill_done = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_DONE;
                    end else begin
                        cnt_d = eff_cnt + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                // One settling cycle; the held access then hits in IDLE.
                stall   = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        memRead;
    logic        memWrite;
    logic        word;
    logic [31:0] read_data;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    always #5 clock = ~clock;

    dcache_ctrl dut (
        .clock      (clock),
        .rst        (rst),
        .address    (address),
        .write_data (write_data),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .word       (word),
        .read_data  (read_data),
        .stall      (stall),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];       // expected load results
    logic [64:0] exp_mem_q[$];   // expected memory beats {we, addr, wdata}
    string       cur_name = "reset";

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s [%s]: got %h expected %h", name, cur_name, got, exp);
        end
    endtask

    // ---------------- main memory model ----------------
    int          wait_cfg = 0;   // cycles mem_ready stays low per word
    int          wait_cnt = 0;
    logic [31:0] mem_model [0:63];

    always_comb mem_ready = (wait_cnt >= wait_cfg);
    always_comb mem_rdata = mem_model[mem_addr[7:2]];

    always @(posedge clock) begin
        if (rst) begin
            wait_cnt <= 0;
            for (int j = 0; j < 64; j++) mem_model[j] <= 32'hDEAD0000 | 32'(j);
            for (int j = 0; j < 4; j++) begin
                mem_model[j]      <= 32'hC0 + 32'(j);   // 0x00..0x0C
                mem_model[8 + j]  <= 32'hA0 + 32'(j);   // 0x20..0x2C
                mem_model[12 + j] <= 32'hD0 + 32'(j);   // 0x30..0x3C
                mem_model[24 + j] <= 32'hB0 + 32'(j);   // 0x60..0x6C
                mem_model[28 + j] <= 32'hF0 + 32'(j);   // 0x70..0x7C
                mem_model[32 + j] <= 32'hE0 + 32'(j);   // 0x80..0x8C
            end
        end else if (mem_req) begin
            if (mem_ready) begin
                wait_cnt <= 0;
                if (mem_we) mem_model[mem_addr[7:2]] <= mem_wdata;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    logic        prev_wait = 1'b0;
    logic [64:0] prev_beat = '0;

    always @(negedge clock) begin
        logic [64:0] e;
        if (rst) begin
            prev_wait = 1'b0;
        end else begin
            if (memRead && !memWrite && !stall) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL load_unexpected [%s]: got %h expected no load", cur_name, read_data);
                end else begin
                    check32("read_data", read_data, exp_q.pop_front());
                end
            end
            if (mem_req && prev_wait) begin
                n_checks++;
                if ({mem_we, mem_addr, mem_wdata} !== prev_beat) begin
                    n_errors++;
                    $display("FAIL mem_hold [%s]: got %h expected %h", cur_name,
                             {mem_we, mem_addr, mem_wdata}, prev_beat);
                end
            end
            if (mem_req && mem_ready) begin
                if (exp_mem_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL mem_unexpected [%s]: got we=%b addr=%h expected no beat", cur_name, mem_we, mem_addr);
                end else begin
                    e = exp_mem_q.pop_front();
                    check32("mem_we", {31'd0, mem_we}, {31'd0, e[64]});
                    check32("mem_addr", mem_addr, e[63:32]);
                    if (e[64]) check32("mem_wdata", mem_wdata, e[31:0]);
                end
            end
            prev_wait = mem_req && !mem_ready;
            prev_beat = {mem_we, mem_addr, mem_wdata};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_refill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_mem_q.push_back({1'b0, base + 32'(4 * i), 32'd0});
    endtask

    task automatic push_wb(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        exp_mem_q.push_back({1'b1, base,          w0});
        exp_mem_q.push_back({1'b1, base + 32'd4,  w1});
        exp_mem_q.push_back({1'b1, base + 32'd8,  w2});
        exp_mem_q.push_back({1'b1, base + 32'd12, w3});
    endtask

    // Called just after a rising edge; returns just after the edge on which
    // the access completes. Checks the number of stalled cycles.
    task automatic cpu_access(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic rd, input logic wr, input logic wd, input int exp_stall);
        int   stalls = 0;
        logic done   = 1'b0;
        logic saw_req = 1'b0;
        cur_name   = name;
        address    = addr;
        write_data = wdata;
        memRead    = rd;
        memWrite   = wr;
        word       = wd;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clock);
            if (mem_req) saw_req = 1'b1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            @(posedge clock);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout [%s]: got stall after %0d cycles expected completion", name, stalls);
        end
        @(posedge clock);
        #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
        check32("stall_cycles", 32'(stalls), 32'(exp_stall));
        if (exp_stall == 0) check32("hit_no_mem_req", {31'd0, saw_req}, 32'd0);
    endtask

    task automatic do_read(input string name, input logic [31:0] addr, input logic wd,
                           input logic [31:0] exp_data, input int exp_stall);
        exp_q.push_back(exp_data);
        cpu_access(name, addr, 32'd0, 1'b1, 1'b0, wd, exp_stall);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic found;
        rst = 1'b1; address = '0; write_data = '0; memRead = 1'b0; memWrite = 1'b0; word = 1'b1;
        repeat (3) @(posedge clock);
        #1 rst = 1'b0;
        @(negedge clock);
        check32("reset_stall",     {31'd0, stall},   32'd0);
        check32("reset_mem_req",   {31'd0, mem_req}, 32'd0);
        check32("reset_mem_we",    {31'd0, mem_we},  32'd0);
        check32("reset_read_data", read_data,        32'd0);
        @(posedge clock);
        #1;

        // Cold clean miss, mem_ready high.
        push_refill(32'h20);
        do_read("cold_miss_24", 32'h24, 1'b1, 32'hA1, 5);
        do_read("hit_28", 32'h28, 1'b1, 32'hA2, 0);

        // Byte store: only write_data[7:0] lands, in lane 1.
        cpu_access("byte_store_25", 32'h25, 32'hDEADBE55, 1'b0, 1'b1, 1'b0, 0);
        do_read("word_after_bstore", 32'h24, 1'b1, 32'h000055A1, 0);
        do_read("byte_read_25", 32'h25, 1'b0, 32'h00000055, 0);
        do_read("byte_read_24", 32'h24, 1'b0, 32'h000000A1, 0);
        do_read("byte_read_27", 32'h27, 1'b0, 32'h00000000, 0);

        // Dirty miss on index 2: writeback then refill.
        push_wb(32'h20, 32'hA0, 32'h000055A1, 32'hA2, 32'hA3);
        push_refill(32'h60);
        do_read("dirty_miss_64", 32'h64, 1'b1, 32'hB1, 9);

        // Write miss with memRead and memWrite both set (treated as store).
        push_refill(32'h30);
        cpu_access("write_miss_34", 32'h34, 32'h12345678, 1'b1, 1'b1, 1'b1, 5);
        do_read("read_back_34", 32'h34, 1'b1, 32'h12345678, 0);

        // Evicting the written line carries the stored word back.
        push_wb(32'h30, 32'hD0, 32'h12345678, 32'hD2, 32'hD3);
        push_refill(32'h70);
        do_read("dirty_miss_7c", 32'h7C, 1'b1, 32'hF3, 9);

        // Slow memory: 3 wait cycles per word, 4*4 stalled beats + DONE.
        wait_cfg = 3;
        push_refill(32'h00);
        do_read("slow_refill_04", 32'h04, 1'b1, 32'hC1, 17);

        // Reset during the second word of a refill.
        cur_name = "reset_mid_refill";
        exp_mem_q.push_back({1'b0, 32'h80, 32'd0});
        address = 32'h84; memRead = 1'b1; word = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clock);
            if (mem_req && mem_addr == 32'h84) begin
                found = 1'b1;
                break;
            end
        end
        check32("second_word_reached", {31'd0, found}, 32'd1);
        @(posedge clock);
        #1 rst = 1'b1; memRead = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #1;
        @(negedge clock);
        check32("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check32("rst_stall",   {31'd0, stall},   32'd0);
        @(posedge clock);
        #1 rst = 1'b0;
        check32("rst_beats_pending", 32'(exp_mem_q.size()), 32'd0);
        wait_cfg = 0;
        @(posedge clock);
        #1;
        push_refill(32'h80);
        do_read("reread_after_rst_84", 32'h84, 1'b1, 32'hE1, 5);
        push_refill(32'h60);
        do_read("idx2_invalid_after_rst", 32'h64, 1'b1, 32'hB1, 5);

        repeat (3) @(posedge clock);
        cur_name = "drain";
        check32("loads_outstanding", 32'(exp_q.size()), 32'd0);
        check32("beats_outstanding", 32'(exp_mem_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        n_errors++;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
